ppl_grid_scanner: RTL and testbench

- Consumer end of the people-grid interface driven by movement_and_collision.
- Snapshots the packed new_ppl_grid when the producer flags it valid, then streams every cell out over a valid/ready write port toward the frame-buffer/BRAM writer.
- Counts occupied cells and returns a one-cycle done pulse, which is fed back as movement_and_collision's done input to pace the next simulation step.

---
 rtl/ppl_grid_scanner.sv | 125 ++++++++++++
 tb/tb_ppl_grid_scanner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ppl_grid_scanner.sv
// ppl_grid_scanner
// Consumer of the people grid: snapshots new_ppl_grid on grid_valid, streams
// every cell over a valid/ready write port, counts occupied cells and pulses
// done once per completed scan.
//
// Ports:
//   clk_in, rst_in     clock, synchronous active-low reset
//   new_ppl_grid       packed grid, cell i at [i*CELL_BITS +: CELL_BITS]
//   grid_valid         single-cycle "grid stable" pulse (only honoured in IDLE)
//   busy               scan in progress (SCAN or FINISH)
//   wr_addr/wr_data    current beat: cell index / cell value
//   wr_valid/wr_ready  beat handshake, no retraction under backpressure
//   pop_count          nonzero cells of the last completed scan
//   done               one-cycle pulse in the FINISH cycle
//   overrun            (GRID_SCANNER_OVERRUN_EN only) sticky: grid_valid seen while busy
//
// Optional feature macro: GRID_SCANNER_OVERRUN_EN
module ppl_grid_scanner #(
  parameter int unsigned GRID_W    = 48,
  parameter int unsigned GRID_H    = 48,
  parameter int unsigned CELL_BITS = 3,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [GRID_W*GRID_H*CELL_BITS-1:0]  new_ppl_grid,
  input  logic                                grid_valid,
  output logic                                busy,
  output logic [ADDR_W-1:0]                   wr_addr,
  output logic [CELL_BITS-1:0]                wr_data,
  output logic                                wr_valid,
  input  logic                                wr_ready,
  output logic [ADDR_W-1:0]                   pop_count,
  output logic                                done
`ifdef GRID_SCANNER_OVERRUN_EN
  ,
  output logic                                overrun
`endif
);

  localparam int unsigned CELLS     = GRID_W * GRID_H;
  localparam int unsigned GRID_BITS = CELLS * CELL_BITS;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CELLS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

  state_t               state;
  // Holds cells not yet presented; cell wr_addr+1 sits in the low bits.
  logic [GRID_BITS-1:0] shadow;
  logic [ADDR_W-1:0]    acc;

  logic accept_c;
  logic last_c;

  assign accept_c = wr_valid & wr_ready;
  assign last_c   = accept_c && (wr_addr == LAST_IDX);

  // Scanner FSM with registered outputs
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      shadow    <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      pop_count <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (grid_valid) begin
            // Cell 0 goes straight to the output register; the rest shifts in later.
            shadow   <= new_ppl_grid >> CELL_BITS;
            wr_data  <= new_ppl_grid[CELL_BITS-1:0];
            wr_addr  <= '0;
            acc      <= '0;
            busy     <= 1'b1;
            wr_valid <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (accept_c) begin
            acc     <= acc + ADDR_W'(|wr_data);
            shadow  <= shadow >> CELL_BITS;
            wr_data <= shadow[CELL_BITS-1:0];
            if (last_c) begin
              wr_valid <= 1'b0;
              done     <= 1'b1;
              state    <= FINISH;
            end else begin
              wr_addr <= wr_addr + ADDR_W'(1);
            end
          end
        end
        FINISH: begin
          // grid_valid is deliberately not looked at here.
          pop_count <= acc;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy     <= 1'b0;
          wr_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef GRID_SCANNER_OVERRUN_EN
  // Sticky flag for a grid offered while a scan is still running
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      overrun <= 1'b0;
    end else if (grid_valid && busy) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ppl_grid_scanner.sv
module tb_ppl_grid_scanner;

  localparam int unsigned GRID_W    = 48;
  localparam int unsigned GRID_H    = 48;
  localparam int unsigned CELL_BITS = 3;
  localparam int unsigned ADDR_W    = 12;
  localparam int          CELLS     = GRID_W * GRID_H;
  localparam int          GB        = CELLS * CELL_BITS;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic [GB-1:0]        new_ppl_grid;
  logic                 grid_valid;
  logic                 busy;
  logic [ADDR_W-1:0]    wr_addr;
  logic [CELL_BITS-1:0] wr_data;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [ADDR_W-1:0]    pop_count;
  logic                 done;
`ifdef GRID_SCANNER_OVERRUN_EN
  logic                 overrun;
`endif

  int checks = 0;
  int errors = 0;

  ppl_grid_scanner #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .CELL_BITS(CELL_BITS), .ADDR_W(ADDR_W)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .new_ppl_grid (new_ppl_grid),
    .grid_valid   (grid_valid),
    .busy         (busy),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .pop_count    (pop_count),
    .done         (done)
`ifdef GRID_SCANNER_OVERRUN_EN
    ,
    .overrun      (overrun)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Called one step after the start edge; follows the scan up to the cycle after done.
  task automatic run_scan(input logic [GB-1:0] g, input bit bp, input int poke_addr,
                          input bit gv_at_done, output int done_cyc, output int ndone,
                          output int acc_n, output int bad);
    bit poked;
    bit seen_done;
    done_cyc  = -1;
    ndone     = 0;
    acc_n     = 0;
    bad       = 0;
    poked     = 1'b0;
    seen_done = 1'b0;
    for (int cyc = 1; cyc <= 6000; cyc++) begin
      grid_valid = 1'b0;
      if (seen_done) break;
      wr_ready = bp ? cyc[0] : 1'b1;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
        seen_done = 1'b1;
        if (gv_at_done) grid_valid = 1'b1;
      end
      if (acc_n < CELLS) begin
        if (wr_valid !== 1'b1 || wr_addr !== ADDR_W'(acc_n) ||
            wr_data !== g[acc_n*CELL_BITS +: CELL_BITS])
          bad++;
        else if (wr_ready)
          acc_n++;
      end else if (wr_valid !== 1'b0) begin
        bad++;
      end
      if (!poked && poke_addr >= 0 && wr_valid && int'(wr_addr) == poke_addr) begin
        new_ppl_grid = '0;
        grid_valid   = 1'b1;
        poked        = 1'b1;
      end
      tick();
    end
  endtask

  task automatic start(input logic [GB-1:0] g);
    new_ppl_grid = g;
    grid_valid   = 1'b1;
    tick();
    grid_valid   = 1'b0;
  endtask

  initial begin
    logic [GB-1:0] g1, g2, g3, g7;
    int done_cyc, ndone, acc_n, bad;
    bit found;

    g1 = '0; g1[101*CELL_BITS +: CELL_BITS] = 3'b101;
    g2 = '0; g2[0 +: CELL_BITS] = 3'd1; g2[(CELLS-1)*CELL_BITS +: CELL_BITS] = 3'd4;
    g3 = '0;
    for (int i = 0; i < 10; i++) g3[i*CELL_BITS +: CELL_BITS] = 3'd2;
    g7 = '1;

    // Reset held with grid_valid asserted
    rst_in = 1'b0; grid_valid = 1'b1; wr_ready = 1'b1; new_ppl_grid = g7;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_pop_count", pop_count, 0);
    chk("rst_wr_addr", wr_addr, 0);
`ifdef GRID_SCANNER_OVERRUN_EN
    chk("rst_overrun", overrun, 0);
`endif
    rst_in = 1'b1; grid_valid = 1'b0;
    tick();
    chk("rst_no_scan", busy, 0);

    // Single occupant, wr_ready held high
    start(g1);
    run_scan(g1, 1'b0, -1, 1'b0, done_cyc, ndone, acc_n, bad);
    chk("single_beats", acc_n, CELLS);
    chk("single_bad_beats", bad, 0);
    chk("single_done_cycle", done_cyc, 2305);
    chk("single_done_count", ndone, 1);
    chk("single_pop", pop_count, 1);
    chk("single_idle", busy, 0);
`ifdef GRID_SCANNER_OVERRUN_EN
    chk("single_overrun", overrun, 0);
`endif

    // Backpressure, ready alternating; grid_valid offered in the FINISH cycle
    start(g1);
    run_scan(g1, 1'b1, -1, 1'b1, done_cyc, ndone, acc_n, bad);
    chk("bp_beats", acc_n, CELLS);
    chk("bp_bad_beats", bad, 0);
    chk("bp_done_cycle", done_cyc, 4608);
    chk("bp_done_count", ndone, 1);
    chk("bp_pop", pop_count, 1);
    chk("finish_gv_ignored", busy, 0);
    chk("finish_gv_no_valid", wr_valid, 0);

    // Snapshot isolation and grid_valid while busy
    start(g7);
    run_scan(g7, 1'b0, 500, 1'b0, done_cyc, ndone, acc_n, bad);
    chk("snap_beats", acc_n, CELLS);
    chk("snap_bad_beats", bad, 0);
    chk("snap_done_cycle", done_cyc, 2305);
    chk("snap_done_count", ndone, 1);
    chk("snap_pop", pop_count, 2304);
    chk("snap_no_restart", busy, 0);
`ifdef GRID_SCANNER_OVERRUN_EN
    chk("snap_overrun", overrun, 1);
`endif

    // Reset in the middle of a scan
    start(g1);
    found = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (wr_valid && wr_addr == ADDR_W'(1000)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("mid_reach_addr_1000", found, 1);
    rst_in = 1'b0;
    tick();
    chk("mid_wr_valid", wr_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_pop", pop_count, 0);
    chk("mid_done", done, 0);
    rst_in = 1'b1;
    tick();
    chk("mid_done_after", done, 0);
    chk("mid_still_idle", busy, 0);
    start(g2);
    chk("restart_addr0", wr_addr, 0);
    run_scan(g2, 1'b0, -1, 1'b0, done_cyc, ndone, acc_n, bad);
    chk("restart_bad_beats", bad, 0);
    chk("restart_done_cycle", done_cyc, 2305);
    chk("restart_pop", pop_count, 2);

    // Back-to-back scans: second grid_valid in the cycle right after done
    start(g3);
    run_scan(g3, 1'b0, -1, 1'b0, done_cyc, ndone, acc_n, bad);
    chk("b2b_first_pop", pop_count, 10);
    chk("b2b_first_bad", bad, 0);
    start(g1);
    chk("b2b_second_busy", busy, 1);
    run_scan(g1, 1'b0, -1, 1'b0, done_cyc, ndone, acc_n, bad);
    chk("b2b_second_beats", acc_n, CELLS);
    chk("b2b_second_bad", bad, 0);
    chk("b2b_second_done_count", ndone, 1);
    chk("b2b_second_pop", pop_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
